hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter SHALL be: MULT_CYCLES, 4, total stall cycles for a multi-cycle op (legal 2..15).
REQ-002 Port clock  input  1  sole clock; all state updates on rising edge.
REQ-003 Port reset  input  1  asynchronous, active-high reset.
REQ-004 Port ID_RS  input  5  rs field of the instruction in ID.
REQ-005 Port ID_RT  input  5  rt field of the instruction in ID.
REQ-006 Port ID_uses_rt  input  1  ID instruction reads rt as a source.
REQ-007 Port ID_mult_start  input  1  ID instruction is a multi-cycle op.
REQ-008 Port EX_MEM_REN  input  1  EX instruction is a load, from the ID/EX register.
REQ-009 Port EX_RT  input  5  load destination register, from the ID/EX register.
REQ-010 Port EX_PC_jump  input  1  jump/taken branch resolved in EX, from the ID/EX register.
REQ-011 Port PC_write  output  1  PC update enable.
REQ-012 Port IF_ID_write  output  1  IF/ID register load enable.
REQ-013 Port IF_ID_flush  output  1  zero the IF/ID register.
REQ-014 Port ID_EX_bubble  output  1  zero the control fields loaded into ID/EX this cycle.
REQ-015 Port busy  output  1  multi-cycle stall in progress.
REQ-016 Port stall_count  output  16  cycles with PC_write=0 since reset.

Function
REQ-017 load_use SHALL be EX_MEM_REN & (EX_RT!=0) & ((EX_RT==ID_RS) | (ID_uses_rt & EX_RT==ID_RT)).
REQ-018 States SHALL be RUN, LDSTALL, FLUSH, MSTALL, held in a registered state variable.
REQ-019 Outputs SHALL be combinational from the current state and the inputs, with no added latency.
REQ-020 RUN, no event: PC_write=1, IF_ID_write=1, IF_ID_flush=0, ID_EX_bubble=0, busy=0; next state RUN.
REQ-021 RUN event priority SHALL be EX_PC_jump > load_use > ID_mult_start.
REQ-022 RUN with EX_PC_jump: PC_write=1, IF_ID_write=1, IF_ID_flush=1, ID_EX_bubble=1; next state FLUSH.
REQ-023 FLUSH: IF_ID_flush=1, PC_write=1, IF_ID_write=1, ID_EX_bubble=1 for exactly one cycle, ignoring all events; next state RUN.
REQ-024 RUN with load_use and no jump: PC_write=0, IF_ID_write=0, ID_EX_bubble=1, IF_ID_flush=0; next state LDSTALL.
REQ-025 LDSTALL: RUN outputs, load_use ignored; EX_PC_jump and ID_mult_start are evaluated as in RUN; with no event, next state RUN.
REQ-026 RUN with ID_mult_start only: PC_write=0, IF_ID_write=0, ID_EX_bubble=1, busy=1, counter loaded with MULT_CYCLES-2; next state MSTALL.
REQ-027 MSTALL: PC_write=0, IF_ID_write=0, ID_EX_bubble=1, busy=1, EX_PC_jump/load_use/ID_mult_start ignored; counter decrements by 1 each cycle.
REQ-028 MSTALL with counter==0: stall outputs still apply that cycle; next state RUN.
REQ-029 Total consecutive PC_write=0 cycles for one multi-cycle op SHALL equal MULT_CYCLES.
REQ-030 Counter SHALL be 4 bits and SHALL never wrap below 0.
REQ-031 stall_count SHALL increment on each rising edge where PC_write=0 and SHALL saturate at 16'hFFFF.

Reset
REQ-032 reset=1 SHALL asynchronously force state=RUN, counter=0 and stall_count=0, and reset SHALL be held for the whole cycle.
REQ-033 During reset, outputs SHALL be PC_write=1, IF_ID_write=1, IF_ID_flush=0, ID_EX_bubble=0, busy=0.
REQ-034 Reset asserted mid-MSTALL or mid-FLUSH SHALL abort the sequence immediately with no residual stall after release.

Verification
REQ-035 EX_MEM_REN=1, EX_RT=8, ID_RS=8 in RUN -> one cycle PC_write=0/ID_EX_bubble=1, then PC_write=1; stall_count=1.
REQ-036 EX_MEM_REN=1, EX_RT=0, ID_RS=0 -> no stall; EX_RT=9=ID_RT with ID_uses_rt=0 -> no stall.
REQ-037 EX_PC_jump=1 with load_use=1 in the same cycle -> IF_ID_flush=1 for 2 cycles, PC_write never 0.
REQ-038 ID_mult_start=1, MULT_CYCLES=4 -> busy=1 and PC_write=0 for exactly 4 cycles, then RUN; stall_count=4.
REQ-039 Reset pulse in the 2nd MSTALL cycle -> outputs return to reset values immediately; no stall after release; stall_count=0.
REQ-040 Force stall_count to 16'hFFFE, then apply 3 stall cycles -> stall_count holds at 16'hFFFF.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, jump flushes and multi-cycle
// operation stalls, with a saturating count of PC-stalled cycles.
module hazard_ctrl #(
  parameter int MULT_CYCLES = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  ID_RS,
  input  logic [4:0]  ID_RT,
  input  logic        ID_uses_rt,
  input  logic        ID_mult_start,
  input  logic        EX_MEM_REN,
  input  logic [4:0]  EX_RT,
  input  logic        EX_PC_jump,
  output logic        PC_write,
  output logic        IF_ID_write,
  output logic        IF_ID_flush,
  output logic        ID_EX_bubble,
  output logic        busy,
  output logic [15:0] stall_count
);

  localparam logic [1:0] RUN     = 2'd0;
  localparam logic [1:0] LDSTALL = 2'd1;
  localparam logic [1:0] FLUSH   = 2'd2;
  localparam logic [1:0] MSTALL  = 2'd3;

  // The entry cycle in RUN is the first stall cycle, so MSTALL runs MULT_CYCLES-1 cycles.
  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 2);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] stall_q, stall_d;
  logic        load_use;
  logic        pc_write_c, ifid_write_c, flush_c, bubble_c, busy_c;

  assign load_use = EX_MEM_REN && (EX_RT != 5'd0) &&
                    ((EX_RT == ID_RS) || (ID_uses_rt && (EX_RT == ID_RT)));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_write_c   = 1'b1;
    ifid_write_c = 1'b1;
    flush_c      = 1'b0;
    bubble_c     = 1'b0;
    busy_c       = 1'b0;
    case (state_q)
      RUN, LDSTALL: begin
        if (EX_PC_jump) begin
          flush_c  = 1'b1;
          bubble_c = 1'b1;
          state_d  = FLUSH;
        end else if (load_use && (state_q == RUN)) begin
          pc_write_c   = 1'b0;
          ifid_write_c = 1'b0;
          bubble_c     = 1'b1;
          state_d      = LDSTALL;
        end else if (ID_mult_start) begin
          pc_write_c   = 1'b0;
          ifid_write_c = 1'b0;
          bubble_c     = 1'b1;
          busy_c       = 1'b1;
          cnt_d        = MULT_LOAD;
          state_d      = MSTALL;
        end else begin
          state_d = RUN;
        end
      end
      FLUSH: begin
        flush_c  = 1'b1;
        bubble_c = 1'b1;
        state_d  = RUN;
      end
      MSTALL: begin
        pc_write_c   = 1'b0;
        ifid_write_c = 1'b0;
        bubble_c     = 1'b1;
        busy_c       = 1'b1;
        if (cnt_q == 4'd0) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Reset overrides the decoded outputs so a stall request cannot leak through.
  always_comb begin
    PC_write     = reset ? 1'b1 : pc_write_c;
    IF_ID_write  = reset ? 1'b1 : ifid_write_c;
    IF_ID_flush  = reset ? 1'b0 : flush_c;
    ID_EX_bubble = reset ? 1'b0 : bubble_c;
    busy         = reset ? 1'b0 : busy_c;
  end

  always_comb begin
    stall_d = stall_q;
    if (!PC_write && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= 4'd0;
      stall_q <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

  assign stall_count = stall_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: each scenario drives inputs on the falling
// edge and checks the combinational outputs 1ns later.
module tb_hazard_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  ID_RS = '0, ID_RT = '0, EX_RT = '0;
  logic        ID_uses_rt = 1'b0, ID_mult_start = 1'b0, EX_MEM_REN = 1'b0, EX_PC_jump = 1'b0;
  logic        PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, busy;
  logic [15:0] stall_count;
  int          checks = 0;
  int          errors = 0;

  hazard_ctrl #(.MULT_CYCLES(4)) dut (
    .clock(clock), .reset(reset), .ID_RS(ID_RS), .ID_RT(ID_RT),
    .ID_uses_rt(ID_uses_rt), .ID_mult_start(ID_mult_start),
    .EX_MEM_REN(EX_MEM_REN), .EX_RT(EX_RT), .EX_PC_jump(EX_PC_jump),
    .PC_write(PC_write), .IF_ID_write(IF_ID_write), .IF_ID_flush(IF_ID_flush),
    .ID_EX_bubble(ID_EX_bubble), .busy(busy), .stall_count(stall_count)
  );

  always #5 clock = ~clock;

  task automatic clear_inputs();
    ID_RS = '0; ID_RT = '0; EX_RT = '0;
    ID_uses_rt = 0; ID_mult_start = 0; EX_MEM_REN = 0; EX_PC_jump = 0;
  endtask

  task automatic do_reset();
    @(negedge clock); reset = 1'b1; clear_inputs();
    @(negedge clock); reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clock); reset = 1'b1; ID_mult_start = 1'b1; EX_PC_jump = 1'b1; #1;
    checks++; if ({PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, busy} !== 5'b11000) begin
      errors++; $display("FAIL rst_outputs: got %b want 11000", {PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, busy}); end
    checks++; if (stall_count !== 16'd0) begin
      errors++; $display("FAIL rst_count: got %0d want 0", stall_count); end
    @(negedge clock); clear_inputs(); #1;
    checks++; if (stall_count !== 16'd0) begin
      errors++; $display("FAIL rst_count_held: got %0d want 0", stall_count); end
    reset = 1'b0;
  endtask

  task automatic test_load_use();
    do_reset();
    @(negedge clock); EX_MEM_REN = 1; EX_RT = 5'd8; ID_RS = 5'd8; #1;
    checks++; if ({PC_write, IF_ID_write, ID_EX_bubble, IF_ID_flush} !== 4'b0010) begin
      errors++; $display("FAIL ld_stall: got %b want 0010", {PC_write, IF_ID_write, ID_EX_bubble, IF_ID_flush}); end
    @(negedge clock); #1;
    checks++; if ({PC_write, IF_ID_write, ID_EX_bubble} !== 3'b110) begin
      errors++; $display("FAIL ld_release: got %b want 110", {PC_write, IF_ID_write, ID_EX_bubble}); end
    checks++; if (stall_count !== 16'd1) begin
      errors++; $display("FAIL ld_count: got %0d want 1", stall_count); end
    clear_inputs();
    @(negedge clock); #1;
    checks++; if (stall_count !== 16'd1) begin
      errors++; $display("FAIL ld_count_hold: got %0d want 1", stall_count); end
  endtask

  task automatic test_no_stall();
    do_reset();
    @(negedge clock); EX_MEM_REN = 1; EX_RT = 5'd0; ID_RS = 5'd0; #1;
    checks++; if ({PC_write, ID_EX_bubble} !== 2'b10) begin
      errors++; $display("FAIL r0_nostall: got %b want 10", {PC_write, ID_EX_bubble}); end
    @(negedge clock); EX_RT = 5'd9; ID_RT = 5'd9; ID_RS = 5'd3; ID_uses_rt = 0; #1;
    checks++; if ({PC_write, ID_EX_bubble} !== 2'b10) begin
      errors++; $display("FAIL rt_unused_nostall: got %b want 10", {PC_write, ID_EX_bubble}); end
    @(negedge clock); ID_uses_rt = 1; #1;
    checks++; if ({PC_write, ID_EX_bubble} !== 2'b01) begin
      errors++; $display("FAIL rt_used_stall: got %b want 01", {PC_write, ID_EX_bubble}); end
    @(negedge clock); clear_inputs(); #1;
    checks++; if (stall_count !== 16'd1) begin
      errors++; $display("FAIL rt_count: got %0d want 1", stall_count); end
  endtask

  task automatic test_jump_priority();
    do_reset();
    @(negedge clock); EX_PC_jump = 1; EX_MEM_REN = 1; EX_RT = 5'd4; ID_RS = 5'd4; ID_mult_start = 1; #1;
    checks++; if ({PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, busy} !== 5'b11110) begin
      errors++; $display("FAIL jmp_c1: got %b want 11110", {PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, busy}); end
    @(negedge clock); #1;
    checks++; if ({PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, busy} !== 5'b11110) begin
      errors++; $display("FAIL jmp_flush_c2: got %b want 11110", {PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, busy}); end
    @(negedge clock); clear_inputs(); #1;
    checks++; if ({PC_write, IF_ID_flush, ID_EX_bubble} !== 3'b100) begin
      errors++; $display("FAIL jmp_done: got %b want 100", {PC_write, IF_ID_flush, ID_EX_bubble}); end
    checks++; if (stall_count !== 16'd0) begin
      errors++; $display("FAIL jmp_count: got %0d want 0", stall_count); end
  endtask

  task automatic test_ldstall_events();
    do_reset();
    @(negedge clock); EX_MEM_REN = 1; EX_RT = 5'd5; ID_RS = 5'd5; #1;
    @(negedge clock); EX_PC_jump = 1; #1;
    checks++; if ({PC_write, IF_ID_flush, ID_EX_bubble} !== 3'b111) begin
      errors++; $display("FAIL ldst_jump: got %b want 111", {PC_write, IF_ID_flush, ID_EX_bubble}); end
    do_reset();
    @(negedge clock); EX_MEM_REN = 1; EX_RT = 5'd5; ID_RS = 5'd5; #1;
    @(negedge clock); ID_mult_start = 1; #1;
    checks++; if ({PC_write, busy, ID_EX_bubble} !== 3'b011) begin
      errors++; $display("FAIL ldst_mult: got %b want 011", {PC_write, busy, ID_EX_bubble}); end
    clear_inputs();
  endtask

  task automatic test_mult();
    do_reset();
    @(negedge clock); ID_mult_start = 1; #1;
    checks++; if ({PC_write, IF_ID_write, ID_EX_bubble, busy} !== 4'b0011) begin
      errors++; $display("FAIL mult_c1: got %b want 0011", {PC_write, IF_ID_write, ID_EX_bubble, busy}); end
    for (int c = 2; c <= 4; c++) begin
      @(negedge clock); ID_mult_start = 0; EX_PC_jump = (c == 3); #1;
      checks++; if ({PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, busy} !== 5'b00011) begin
        errors++; $display("FAIL mult_c%0d: got %b want 00011", c, {PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, busy}); end
    end
    @(negedge clock); clear_inputs(); #1;
    checks++; if ({PC_write, busy, ID_EX_bubble} !== 3'b100) begin
      errors++; $display("FAIL mult_done: got %b want 100", {PC_write, busy, ID_EX_bubble}); end
    checks++; if (stall_count !== 16'd4) begin
      errors++; $display("FAIL mult_count: got %0d want 4", stall_count); end
  endtask

  task automatic test_reset_mid_mstall();
    do_reset();
    @(negedge clock); ID_mult_start = 1; #1;
    @(negedge clock); ID_mult_start = 0; reset = 1; #1;
    checks++; if ({PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, busy} !== 5'b11000) begin
      errors++; $display("FAIL mrst_outputs: got %b want 11000", {PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, busy}); end
    checks++; if (stall_count !== 16'd0) begin
      errors++; $display("FAIL mrst_count: got %0d want 0", stall_count); end
    @(negedge clock); reset = 0; #1;
    checks++; if ({PC_write, busy} !== 2'b10) begin
      errors++; $display("FAIL mrst_after1: got %b want 10", {PC_write, busy}); end
    @(negedge clock); #1;
    checks++; if ({PC_write, busy} !== 2'b10) begin
      errors++; $display("FAIL mrst_after2: got %b want 10", {PC_write, busy}); end
    checks++; if (stall_count !== 16'd0) begin
      errors++; $display("FAIL mrst_count_after: got %0d want 0", stall_count); end
  endtask

  task automatic test_saturate();
    do_reset();
    @(negedge clock); ID_mult_start = 1;
    repeat (65534) @(posedge clock);
    @(negedge clock); #1;
    checks++; if (stall_count !== 16'hFFFE) begin
      errors++; $display("FAIL sat_fffe: got %h want fffe", stall_count); end
    repeat (3) @(posedge clock);
    @(negedge clock); #1;
    checks++; if (stall_count !== 16'hFFFF) begin
      errors++; $display("FAIL sat_ffff: got %h want ffff", stall_count); end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_stall();
    test_jump_priority();
    test_ldstall_events();
    test_mult();
    test_reset_mid_mstall();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
